// File: rtl/weight_buf_rd_sched_if.sv
// ---------------------------------------------------------------------------
// weight_buf_rd_sched_if
//   Groups the command, buffer-read and output-stream signals of the weight
//   buffer read scheduler into one bundle.
//
//   Command   : cmd_valid / cmd_ready / cmd_base / cmd_len
//   Buffer    : mem_ena / mem_addr (scheduler -> buffer), mem_dout (buffer -> scheduler)
//   Output    : out_valid / out_ready / out_data / out_last
//   Status    : busy, done
//
//   Modports
//     master : the scheduler itself
//     slave  : the surrounding logic (command source, buffer, consumer)
// ---------------------------------------------------------------------------
interface weight_buf_rd_sched_if #(
    parameter int unsigned BUF_ADDR_W = 16,
    parameter int unsigned WIDTH      = 128
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [BUF_ADDR_W-1:0] cmd_base;
    logic [BUF_ADDR_W:0]   cmd_len;

    logic                  mem_ena;
    logic [BUF_ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_dout;

    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;

    logic                  busy;
    logic                  done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, mem_dout, out_ready,
        output cmd_ready, mem_ena, mem_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, mem_dout, out_ready,
        input  cmd_ready, mem_ena, mem_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/weight_buf_rd_sched.sv
// ---------------------------------------------------------------------------
// weight_buf_rd_sched
//   Turns a (base, length) read command into a stream of buffer reads and
//   delivers the returned words, in order, on a valid/ready output stream.
//   Reads are only issued when the output FIFO is guaranteed to have room
//   for them, so the fixed-latency buffer port never needs a stall.
//
// Ports
//   clka      in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bus       if   master side of weight_buf_rd_sched_if:
//                  cmd_*  command handshake (cmd_len = 0 is legal)
//                  mem_*  buffer read port, data returns RD_LAT cycles after mem_ena
//                  out_*  output stream, out_last marks the final word
//                  busy   command in progress, done one-cycle completion pulse
//
// FIFO_DEPTH must be at least RD_LAT+2 to sustain one word per cycle.
// ---------------------------------------------------------------------------
module weight_buf_rd_sched #(
    parameter int unsigned BUF_ADDR_W = 16,
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                   clka,
    input logic                   rst_n,
    weight_buf_rd_sched_if.master bus
);
    localparam int unsigned LEN_W = BUF_ADDR_W + 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Control state
    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [BUF_ADDR_W-1:0] r_base;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_issue_cnt;

    // Tag pipeline shadowing the buffer read latency
    logic [RD_LAT-1:0]     r_tag_vld;
    logic [RD_LAT-1:0]     r_tag_last;
    logic [RD_LAT-1:0]     w_tag_vld_nxt;
    logic [RD_LAT-1:0]     w_tag_last_nxt;

    // Output FIFO
    logic [WIDTH-1:0]      r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_cnt;

    logic                  w_idle;
    logic                  w_accept;
    logic                  w_len_zero;
    logic [CNT_W-1:0]      w_inflight;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_out_valid;
    logic                  w_out_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Command acceptance and issue credit
    // -----------------------------------------------------------------------
    assign w_idle     = (r_state == StIdle);
    assign w_accept   = bus.cmd_valid && w_idle;
    assign w_len_zero = (bus.cmd_len == '0);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            w_inflight = w_inflight + CNT_W'(r_tag_vld[i]);
        end
    end

    // Pops in the same cycle are deliberately not credited: this keeps the
    // credit check off the out_ready path and still sustains full rate when
    // FIFO_DEPTH >= RD_LAT+2.
    assign w_credit_ok  = (w_inflight + r_fifo_cnt) < CNT_W'(FIFO_DEPTH);
    assign w_issue      = (r_state == StIssue) && w_credit_ok;
    assign w_last_issue = w_issue && (r_issue_cnt == (r_len - LEN_W'(1)));

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_len_zero) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = StIssue;
                    end
                end
            end
            StIssue: begin
                if (w_last_issue) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (w_pop && w_out_last) begin
                    w_state_nxt = StIdle;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_done      <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_accept && !w_len_zero) begin
                r_base      <= bus.cmd_base;
                r_len       <= bus.cmd_len;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                r_issue_cnt <= r_issue_cnt + LEN_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tag pipeline: stage RD_LAT-1 lines up with the cycle mem_dout is valid
    // -----------------------------------------------------------------------
    always_comb begin
        w_tag_vld_nxt     = '0;
        w_tag_last_nxt    = '0;
        w_tag_vld_nxt[0]  = w_issue;
        w_tag_last_nxt[0] = w_last_issue;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            w_tag_vld_nxt[i]  = r_tag_vld[i-1];
            w_tag_last_nxt[i] = r_tag_last[i-1];
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld  <= '0;
            r_tag_last <= '0;
        end else begin
            r_tag_vld  <= w_tag_vld_nxt;
            r_tag_last <= w_tag_last_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO
    // -----------------------------------------------------------------------
    assign w_push      = r_tag_vld[RD_LAT-1];
    assign w_out_valid = (r_fifo_cnt != '0);
    assign w_out_last  = w_out_valid && r_fifo_last[r_rd_ptr];
    assign w_pop       = w_out_valid && bus.out_ready;

    // Storage needs no reset: out_data/out_last are masked while the FIFO is empty.
    always_ff @(posedge clka) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= bus.mem_dout;
            r_fifo_last[r_wr_ptr] <= r_tag_last[RD_LAT-1];
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.cmd_ready = w_idle;
    assign bus.mem_ena   = w_issue;
    assign bus.mem_addr  = r_base + r_issue_cnt[BUF_ADDR_W-1:0];
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.out_last  = w_out_last;
    assign bus.busy      = !w_idle;
    assign bus.done      = r_done;

    // The credit rule must make FIFO overflow impossible.
    a_no_push_when_full: assert property (
        @(posedge clka) disable iff (!rst_n)
        !(w_push && (r_fifo_cnt == CNT_W'(FIFO_DEPTH)))
    );

    a_credit_bound: assert property (
        @(posedge clka) disable iff (!rst_n)
        (w_inflight + r_fifo_cnt) <= CNT_W'(FIFO_DEPTH)
    );
endmodule

// File: tb/tb_weight_buf_rd_sched.sv
module tb_weight_buf_rd_sched;
    localparam int unsigned BUF_ADDR_W = 16;
    localparam int unsigned WIDTH      = 128;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef logic [WIDTH-1:0] word_t;
    typedef struct packed {
        word_t data;
        logic  last;
    } beat_t;

    localparam word_t JUNK = {8{16'hDEAD}};

    logic clka  = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    weight_buf_rd_sched_if #(.BUF_ADDR_W(BUF_ADDR_W), .WIDTH(WIDTH)) bus ();

    weight_buf_rd_sched #(
        .BUF_ADDR_W(BUF_ADDR_W),
        .WIDTH     (WIDTH),
        .RD_LAT    (RD_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clka (clka),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    // Scoreboard and event bookkeeping
    logic [BUF_ADDR_W-1:0] addr_q[$];
    beat_t                 exp_q[$];
    int cyc = 0;
    int n_acc = 0, n_reads = 0, n_ov = 0, n_done = 0;
    int acc_cyc = 0, rd_at_acc = 0, first_rd = -1, last_rd = -1, first_ov = -1;
    int last_hs = -1, done_cyc = -1;
    bit    stall = 1'b0;
    word_t stall_data;
    logic  stall_last;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t word_of(input logic [BUF_ADDR_W-1:0] a);
        return {4{a ^ 16'h5A3C, ~a}};
    endfunction

    // Buffer model: fixed RD_LAT latency, junk when no read is returning
    logic                  pend_ena = 1'b0;
    logic [BUF_ADDR_W-1:0] pend_addr = '0;
    logic [RD_LAT-1:0]     pipe_vld = '0;
    word_t                 pipe_data [RD_LAT];

    always @(posedge clka) begin
        cyc <= cyc + 1;
        pipe_vld[0]  <= pend_ena;
        pipe_data[0] <= word_of(pend_addr);
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    assign bus.mem_dout = pipe_vld[RD_LAT-1] ? pipe_data[RD_LAT-1] : JUNK;

    // Monitor on the falling edge
    always @(negedge clka) begin
        beat_t b;
        pend_ena  = bus.mem_ena;
        pend_addr = bus.mem_addr;
        if (rst_n) begin
            check("ready_vs_busy", word_t'(bus.cmd_ready), word_t'(!bus.busy));
            if (bus.cmd_valid && bus.cmd_ready) begin
                n_acc++;
                acc_cyc   = cyc;
                rd_at_acc = n_reads;
                first_rd  = -1;
                first_ov  = -1;
            end
            if (bus.mem_ena) begin
                n_reads++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (addr_q.size() == 0) begin
                check("mem_ena_unexpected", word_t'(bus.mem_ena), word_t'(0));
            end else if (bus.mem_ena) begin
                check("mem_addr", word_t'(bus.mem_addr), word_t'(addr_q.pop_front()));
            end
            if (bus.out_valid) begin
                n_ov++;
                if (first_ov < 0) first_ov = cyc;
            end
            if (stall) begin
                check("hold_valid", word_t'(bus.out_valid), word_t'(1));
                check("hold_data", bus.out_data, stall_data);
                check("hold_last", word_t'(bus.out_last), word_t'(stall_last));
            end
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", word_t'(bus.out_valid), word_t'(0));
            end else if (bus.out_valid && bus.out_ready) begin
                b = exp_q.pop_front();
                check("beat_data", bus.out_data, b.data);
                check("beat_last", word_t'(bus.out_last), word_t'(b.last));
                if (b.last) last_hs = cyc;
            end
            stall      = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
            if (bus.done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic push_expect(input logic [BUF_ADDR_W-1:0] base, input logic [BUF_ADDR_W:0] len);
        for (int i = 0; i < int'(len); i++) begin
            logic [BUF_ADDR_W-1:0] a;
            beat_t b;
            a      = base + BUF_ADDR_W'(i);
            b.data = word_of(a);
            b.last = (i == int'(len) - 1);
            addr_q.push_back(a);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_cmd(input logic [BUF_ADDR_W-1:0] base, input logic [BUF_ADDR_W:0] len,
                            input bit keep);
        int start;
        start = n_acc;
        push_expect(base, len);
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 300 && n_acc == start; i++) tick();
        check("cmd_accepted", word_t'(n_acc - start), word_t'(1));
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int start;
        start = n_done;
        for (int i = 0; i < 300 && n_done == start; i++) tick();
        check(tag, word_t'(n_done - start), word_t'(1));
    endtask

    task automatic check_drained(input string pfx);
        check({pfx, "_exp_left"}, word_t'(exp_q.size()), word_t'(0));
        check({pfx, "_addr_left"}, word_t'(addr_q.size()), word_t'(0));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, word_t'(bus.cmd_ready), word_t'(1));
        check({pfx, "_mem_ena"}, word_t'(bus.mem_ena), word_t'(0));
        check({pfx, "_mem_addr"}, word_t'(bus.mem_addr), word_t'(0));
        check({pfx, "_out_valid"}, word_t'(bus.out_valid), word_t'(0));
        check({pfx, "_out_data"}, bus.out_data, word_t'(0));
        check({pfx, "_out_last"}, word_t'(bus.out_last), word_t'(0));
        check({pfx, "_busy"}, word_t'(bus.busy), word_t'(0));
        check({pfx, "_done"}, word_t'(bus.done), word_t'(0));
    endtask

    initial begin
        int r0, v0, start;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("rst");
        repeat (3) @(posedge clka);
        #1 rst_n = 1'b1;
        tick();

        // Single command
        send_cmd(16'h0010, 17'd4, 1'b0);
        wait_done("t1_done");
        check("t1_first_rd", word_t'(first_rd), word_t'(acc_cyc + 1));
        check("t1_last_rd", word_t'(last_rd), word_t'(acc_cyc + 4));
        check("t1_first_ov", word_t'(first_ov), word_t'(acc_cyc + int'(RD_LAT) + 2));
        check("t1_done_lat", word_t'(done_cyc), word_t'(last_hs + 1));
        check_drained("t1");

        // Address wrap
        send_cmd(16'hFFFE, 17'd3, 1'b0);
        wait_done("t2_done");
        check_drained("t2");

        // Backpressure
        bus.out_ready = 1'b0;
        send_cmd(16'h0100, 17'd16, 1'b0);
        repeat (10) tick();
        check("t3_reads_stalled", word_t'(n_reads - rd_at_acc), word_t'(FIFO_DEPTH));
        bus.out_ready = 1'b1;
        wait_done("t3_done");
        check("t3_reads_total", word_t'(n_reads - rd_at_acc), word_t'(16));
        check_drained("t3");

        // Random backpressure
        send_cmd(16'h0700, 17'd9, 1'b0);
        start = n_done;
        for (int i = 0; i < 400 && n_done == start; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("t3b_done", word_t'(n_done - start), word_t'(1));
        bus.out_ready = 1'b1;
        check_drained("t3b");

        // Zero length
        r0 = n_reads;
        v0 = n_ov;
        send_cmd(16'h0200, 17'd0, 1'b0);
        wait_done("t4_done");
        check("t4_done_lat", word_t'(done_cyc), word_t'(acc_cyc + 1));
        repeat (5) tick();
        check("t4_no_reads", word_t'(n_reads - r0), word_t'(0));
        check("t4_no_out", word_t'(n_ov - v0), word_t'(0));
        check("t4_ready", word_t'(bus.cmd_ready), word_t'(1));

        // Reset mid-command
        send_cmd(16'h0300, 17'd16, 1'b0);
        for (int i = 0; i < 50 && (n_reads - rd_at_acc) < 5; i++) tick();
        check("t5_reads_before_rst", word_t'(n_reads - rd_at_acc), word_t'(5));
        rst_n = 1'b0;
        #1 check_reset_outputs("t5");
        addr_q.delete();
        exp_q.delete();
        stall = 1'b0;
        #1 rst_n = 1'b1;
        r0 = n_reads;
        v0 = n_ov;
        repeat (20) tick();
        check("t5_no_reads", word_t'(n_reads - r0), word_t'(0));
        check("t5_no_out", word_t'(n_ov - v0), word_t'(0));
        check("t5_idle", word_t'(bus.busy), word_t'(0));
        send_cmd(16'h0040, 17'd2, 1'b0);
        wait_done("t5_recover_done");
        check_drained("t5");

        // Back-to-back with cmd_valid held high
        send_cmd(16'h0500, 17'd3, 1'b1);
        send_cmd(16'h0600, 17'd2, 1'b0);
        check("t6_b2b_accept", word_t'(acc_cyc), word_t'(done_cyc));
        wait_done("t6_done");
        check_drained("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "time limit");
    end
endmodule
